// File: rtl/vec_accel_pkg.sv
// Shared opcodes, register index type and engine state encoding for the vector accelerator.
package vec_accel_pkg;
  localparam logic [3:0] CLS_LOAD = 4'h1;
  localparam logic [3:0] CLS_VOP  = 4'h8;
  localparam logic [3:0] CLS_RED  = 4'h9;

  localparam logic [3:0] F_RET  = 4'h1;
  localparam logic [3:0] F_ADDS = 4'hF;
  localparam logic [3:0] F_SUBS = 4'hE;
  localparam logic [3:0] F_MULS = 4'hD;
  localparam logic [3:0] F_ANDS = 4'hC;
  localparam logic [3:0] F_ORS  = 4'hB;
  localparam logic [3:0] F_XORS = 4'hA;

  localparam logic [3:0] F_SUM = 4'h8;
  localparam logic [3:0] F_OR  = 4'h9;
  localparam logic [3:0] F_AND = 4'hA;
  localparam logic [3:0] F_MAX = 4'hB;

  typedef logic [1:0] reg_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARG1, ST_ARG2, ST_LOAD_DATA, ST_EXEC, ST_EMIT
  } engine_state_t;

  // Scalar ops occupy the contiguous code range 0xA..0xF.
  function automatic logic is_scalar_func(input logic [3:0] f);
    return f >= F_XORS;
  endfunction

  function automatic logic [7:0] red_identity(input logic [3:0] f);
    return (f == F_AND) ? 8'hFF : 8'h00;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr_reg, rptr_reg;
  logic         do_wr, do_rd;

  assign empty = (wptr_reg == rptr_reg);
  assign full  = (wptr_reg[AW] != rptr_reg[AW]) && (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign dout  = mem[rptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (do_wr) wptr_reg <= wptr_reg + 1'b1;
      if (do_rd) rptr_reg <= rptr_reg + 1'b1;
    end
  end
endmodule

// File: rtl/vec_accel_top.sv
// UART-driven vector accelerator: rx -> input FIFO -> command engine over 4 vector
// registers -> output FIFO -> tx.
module vec_accel_top
  import vec_accel_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 10_000_000,
  parameter int N              = 8,
  parameter int MULT_SHIFT     = 0,
  parameter int IN_FIFO_DEPTH  = 4,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_l,
  input  logic rx,
  output logic tx
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB) + 1;
  localparam int LW   = $clog2(N + 1);
  localparam int AW   = $clog2(4 * N);

  logic             rx_s1_reg, rx_s2_reg, rx_prev_reg, rx_busy_reg, rx_valid_reg;
  logic [CW-1:0]    rx_cnt_reg, tx_cnt_reg;
  logic [3:0]       rx_bit_reg, tx_bit_reg;
  logic [7:0]       rx_shift_reg;
  logic             tx_reg, tx_busy_reg;
  logic [8:0]       tx_shift_reg;
  logic             in_full, in_empty, in_pop, out_full, out_empty, out_pop, out_push;
  logic [7:0]       in_bus, out_dout, out_byte;
  wire  [7:0]       out_bus;

  engine_state_t    state_reg;
  logic [3:0]       cls_reg, func_reg;
  reg_idx_t         dst_reg, src_reg, rd_src;
  logic [7:0]       arg2_reg, acc_reg, rd_data_reg, vop_res, red_res, mem_wd;
  logic [LW-1:0]    idx_reg, rd_idx, src_len;
  logic [LW-1:0]    len_reg [4];
  logic             hdr_reg, mem_we;
  logic [AW-1:0]    mem_wa, rd_addr;
  logic [7:0]       vmem [4*N];

  // RX: start is re-checked half a bit after the falling edge, then one sample per bit.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      rx_s1_reg <= 1'b1; rx_s2_reg <= 1'b1; rx_prev_reg <= 1'b1;
      rx_busy_reg <= 1'b0; rx_valid_reg <= 1'b0;
      rx_cnt_reg <= '0; rx_bit_reg <= '0; rx_shift_reg <= '0;
    end else begin
      rx_s1_reg    <= rx;
      rx_s2_reg    <= rx_s1_reg;
      rx_prev_reg  <= rx_s2_reg;
      rx_valid_reg <= 1'b0;
      if (!rx_busy_reg) begin
        if (rx_prev_reg && !rx_s2_reg) begin
          rx_busy_reg <= 1'b1; rx_cnt_reg <= '0; rx_bit_reg <= '0;
        end
      end else if (rx_cnt_reg == ((rx_bit_reg == 4'd0) ? CW'(HALF - 1) : CW'(CPB - 1))) begin
        rx_cnt_reg <= '0;
        if (rx_bit_reg == 4'd0) begin
          if (rx_s2_reg) rx_busy_reg <= 1'b0;
          else           rx_bit_reg  <= 4'd1;
        end else if (rx_bit_reg == 4'd9) begin
          rx_busy_reg  <= 1'b0;
          rx_valid_reg <= rx_s2_reg;
        end else begin
          rx_shift_reg <= {rx_s2_reg, rx_shift_reg[7:1]};
          rx_bit_reg   <= rx_bit_reg + 4'd1;
        end
      end else begin
        rx_cnt_reg <= rx_cnt_reg + 1'b1;
      end
    end
  end

  sync_fifo #(.W(8), .DEPTH(IN_FIFO_DEPTH)) u_in_fifo (
    .clk(clk), .rst_l(rst_l), .wr_en(rx_valid_reg), .din(rx_shift_reg), .full(in_full),
    .rd_en(in_pop), .dout(in_bus), .empty(in_empty)
  );

  sync_fifo #(.W(8), .DEPTH(OUT_FIFO_DEPTH)) u_out_fifo (
    .clk(clk), .rst_l(rst_l), .wr_en(out_push), .din(out_byte), .full(out_full),
    .rd_en(out_pop), .dout(out_dout), .empty(out_empty)
  );

  assign out_pop = !tx_busy_reg && !out_empty;
  assign tx      = tx_reg;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      tx_reg <= 1'b1; tx_busy_reg <= 1'b0;
      tx_cnt_reg <= '0; tx_bit_reg <= '0; tx_shift_reg <= '0;
    end else if (!tx_busy_reg) begin
      if (!out_empty) begin
        tx_busy_reg <= 1'b1; tx_reg <= 1'b0;
        tx_shift_reg <= {1'b1, out_dout};
        tx_cnt_reg <= '0; tx_bit_reg <= '0;
      end
    end else if (tx_cnt_reg == CW'(CPB - 1)) begin
      tx_cnt_reg <= '0;
      if (tx_bit_reg == 4'd9) begin
        tx_busy_reg <= 1'b0;
      end else begin
        tx_reg       <= tx_shift_reg[0];
        tx_shift_reg <= {1'b0, tx_shift_reg[8:1]};
        tx_bit_reg   <= tx_bit_reg + 4'd1;
      end
    end else begin
      tx_cnt_reg <= tx_cnt_reg + 1'b1;
    end
  end

  assign src_len  = len_reg[src_reg];
  assign in_pop   = (state_reg != ST_EXEC) && (state_reg != ST_EMIT) && !in_empty;
  assign out_push = (state_reg == ST_EMIT) && (!out_full || out_pop);
  assign out_byte = (cls_reg == CLS_RED) ? acc_reg : (hdr_reg ? 8'(src_len) : rd_data_reg);
  assign out_bus  = out_push ? out_byte : 8'bz;
  assign rd_addr  = AW'(int'(rd_src) * N + int'(rd_idx));

  // The read address is steered one cycle ahead so rd_data_reg holds element idx_reg.
  always_comb begin
    rd_src = src_reg;
    rd_idx = '0;
    case (state_reg)
      ST_ARG1: rd_src = in_bus[1:0];
      ST_EXEC: rd_idx = idx_reg + 1'b1;
      ST_EMIT: rd_idx = (out_push && !hdr_reg) ? idx_reg + 1'b1 : idx_reg;
      default: ;
    endcase
  end

  always_comb begin
    case (func_reg)
      F_ADDS:  vop_res = rd_data_reg + arg2_reg;
      F_SUBS:  vop_res = rd_data_reg - arg2_reg;
      F_MULS:  vop_res = 8'((16'(rd_data_reg) * 16'(arg2_reg)) >> MULT_SHIFT);
      F_ANDS:  vop_res = rd_data_reg & arg2_reg;
      F_ORS:   vop_res = rd_data_reg | arg2_reg;
      default: vop_res = rd_data_reg ^ arg2_reg;
    endcase
    case (func_reg)
      F_SUM:   red_res = acc_reg + rd_data_reg;
      F_OR:    red_res = acc_reg | rd_data_reg;
      F_AND:   red_res = acc_reg & rd_data_reg;
      default: red_res = (rd_data_reg > acc_reg) ? rd_data_reg : acc_reg;
    endcase
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = AW'(int'(dst_reg) * N + int'(idx_reg));
    mem_wd = in_bus;
    if (state_reg == ST_LOAD_DATA) begin
      mem_we = in_pop && (idx_reg < LW'(N));
    end else if (state_reg == ST_EXEC && cls_reg == CLS_VOP && idx_reg != src_len) begin
      mem_we = 1'b1;
      mem_wd = vop_res;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) vmem[mem_wa] <= mem_wd;
    rd_data_reg <= vmem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_reg <= ST_IDLE;
      cls_reg <= '0; func_reg <= '0; dst_reg <= '0; src_reg <= '0;
      arg2_reg <= '0; acc_reg <= '0; idx_reg <= '0; hdr_reg <= 1'b0;
      for (int i = 0; i < 4; i++) len_reg[i] <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (!in_empty) begin
          cls_reg <= in_bus[7:4];
          if (in_bus[7:4] == CLS_LOAD || in_bus[7:4] == CLS_VOP || in_bus[7:4] == CLS_RED)
            state_reg <= ST_ARG1;
        end
        ST_ARG1: if (!in_empty) begin
          func_reg <= in_bus[7:4];
          src_reg  <= in_bus[1:0];
          dst_reg  <= (cls_reg == CLS_LOAD) ? in_bus[1:0] : in_bus[3:2];
          idx_reg  <= '0;
          hdr_reg  <= 1'b1;
          acc_reg  <= red_identity(in_bus[7:4]);
          if (cls_reg == CLS_LOAD) state_reg <= ST_ARG2;
          else if (cls_reg == CLS_VOP && in_bus[7:4] == F_RET) state_reg <= ST_EMIT;
          else if (cls_reg == CLS_VOP && is_scalar_func(in_bus[7:4])) state_reg <= ST_ARG2;
          else if (cls_reg == CLS_RED && in_bus[7:4] >= F_SUM && in_bus[7:4] <= F_MAX)
            state_reg <= ST_EXEC;
          else state_reg <= ST_IDLE;
        end
        ST_ARG2: if (!in_empty) begin
          arg2_reg <= in_bus;
          if (cls_reg == CLS_LOAD) begin
            len_reg[dst_reg] <= (in_bus > 8'(N)) ? LW'(N) : LW'(in_bus);
            state_reg <= (in_bus == 8'd0) ? ST_IDLE : ST_LOAD_DATA;
          end else begin
            state_reg <= ST_EXEC;
          end
        end
        // arg2_reg counts the data bytes still owed; bytes past N are drained unused.
        ST_LOAD_DATA: if (!in_empty) begin
          if (idx_reg < LW'(N)) idx_reg <= idx_reg + 1'b1;
          arg2_reg <= arg2_reg - 8'd1;
          if (arg2_reg == 8'd1) state_reg <= ST_IDLE;
        end
        ST_EXEC: begin
          if (idx_reg == src_len) begin
            if (cls_reg == CLS_VOP) begin
              len_reg[dst_reg] <= src_len;
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_EMIT;
            end
          end else begin
            idx_reg <= idx_reg + 1'b1;
            acc_reg <= red_res;
          end
        end
        ST_EMIT: if (out_push) begin
          if (cls_reg == CLS_RED) begin
            state_reg <= ST_IDLE;
          end else if (hdr_reg) begin
            hdr_reg <= 1'b0;
            if (src_len == '0) state_reg <= ST_IDLE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
            if (idx_reg + 1'b1 == src_len) state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  wire unused_sink = &{1'b0, in_full, out_bus};
endmodule

// File: tb/tb_vec_accel_top.sv
// Scoreboard bench: commands go in over rx, a serial monitor on tx pops expected bytes.
module tb_vec_accel_top;
  import vec_accel_pkg::*;

  localparam int CPB = 10;
  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic rx = 1'b1;
  logic tx;
  int   tests = 0;
  int   fails = 0;
  int   bad_seen = 0;
  bit   mon_en = 1'b1;
  logic [7:0] exp_q [$];

  vec_accel_top dut (.clk(clk), .rst_l(rst_l), .rx(rx), .tx(tx));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_cmd(input bq_t bytes);
    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
  endtask

  task automatic expect_bytes(input bq_t bytes);
    foreach (bytes[i]) exp_q.push_back(bytes[i]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (150) @(negedge clk);
  endtask

  // Watch for the corrupted frame ever reaching the head of the input FIFO.
  always @(negedge clk) begin
    if (rst_l === 1'b1 && dut.in_empty === 1'b0 && dut.in_bus === 8'hA5) bad_seen <= bad_seen + 1;
  end

  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge tx);
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      if (!mon_en) begin
        $display("[TB] tx byte %02h discarded", b);
      end else if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_unexpected: got %02h, expected no byte", b);
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", b, e);
        $display("[TB] tx byte %02h expected %02h", b, e);
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (5) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_in_empty", dut.in_empty, 1);
    check("rst_out_empty", dut.out_empty, 1);
    check("rst_state", 32'(dut.state_reg), 32'(ST_IDLE));
    for (int i = 0; i < 4; i++) check($sformatf("rst_len%0d", i), 32'(dut.len_reg[i]), 0);

    expect_bytes('{8'h03, 8'h19, 8'hE0, 8'h07});
    send_cmd('{8'h10, 8'h00, 8'h03, 8'h19, 8'hE0, 8'h07, 8'h80, 8'h10});
    drain("load_ret");

    expect_bytes('{8'h03, 8'h1C, 8'hE3, 8'h0A});
    send_cmd('{8'h80, 8'hF0, 8'h03, 8'h80, 8'h10});
    drain("adds");

    expect_bytes('{8'hFF});
    send_cmd('{8'h90, 8'h90});
    drain("red_or");

    expect_bytes('{8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
    send_cmd('{8'h10, 8'h01, 8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
               8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h80, 8'h11});
    drain("load_over_n");
    check("len_b", 32'(dut.len_reg[1]), 8);

    expect_bytes('{8'h08, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0, 8'h00});
    send_cmd('{8'h80, 8'hD9, 8'h20, 8'h80, 8'h12});
    drain("muls");

    expect_bytes('{8'hE0});
    send_cmd('{8'h90, 8'hB2});
    drain("red_max");

    expect_bytes('{8'h08, 8'hF0, 8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0});
    send_cmd('{8'h80, 8'hEA, 8'h30, 8'h80, 8'h12});
    drain("subs_inplace");

    send_byte(8'hA5, 1'b0);
    send_byte(8'h50, 1'b1);
    drain("bad_frame");
    check("bad_frame_hidden", bad_seen, 0);
    expect_bytes('{8'h09});
    send_cmd('{8'h90, 8'h80});
    drain("after_bad");

    mon_en = 1'b0;
    send_cmd('{8'h80, 8'h10});
    begin
      int n;
      n = 0;
      while (tx !== 1'b0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
    end
    check("ret_tx_started", tx, 0);
    repeat (2) @(negedge clk);
    rst_l = 1'b0;
    @(posedge clk);
    #1;
    check("reset_tx_high", tx, 1);
    for (int i = 0; i < 4; i++) check($sformatf("reset_len%0d", i), 32'(dut.len_reg[i]), 0);
    @(negedge clk);
    rst_l = 1'b1;
    repeat (200) @(negedge clk);
    check("reset_out_empty", dut.out_empty, 1);
    mon_en = 1'b1;

    expect_bytes('{8'h00});
    send_cmd('{8'h80, 8'h10});
    drain("ret_after_reset");

    expect_bytes('{8'hFF, 8'h00});
    send_cmd('{8'h90, 8'hA2, 8'h90, 8'h80});
    drain("red_empty");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
